// File: rtl/pixel_fetch.sv
// Pixel fetch: reads 64-bit phrases from memory and extracts one 1..32 bpp pixel,
// with an optional single-phrase hold register that serves repeat reads of the same phrase.
module pixel_fetch #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_address,
  input  logic [2:0]  req_pixa,
  input  logic [2:0]  req_pixsize,
  input  logic        inval,
  output logic        mem_req,
  output logic [20:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_dvalid,
  input  logic [63:0] mem_data,
  output logic        pix_valid,
  output logic [31:0] pix_data,
  input  logic        pix_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  byte_r;
  logic [2:0]  pixa_r;
  logic [2:0]  size_r;
  logic [63:0] hold_r;
  logic [20:0] tag_r;
  logic        tag_valid_r;
  logic [20:0] mem_addr_r;
  logic [31:0] pix_data_r;
  logic        accept_s;
  logic        hit_s;
  logic        capture_s;

  // Codes 6 and 7 alias 16 and 32 bpp; the bit index is aligned down to the pixel width.
  function automatic logic [31:0] extract(input logic [63:0] phrase, input logic [2:0] byte_sel,
                                          input logic [2:0] pixa, input logic [2:0] size);
    logic [2:0]  code;
    logic [5:0]  index;
    logic [31:0] mask;
    logic [63:0] shifted;
    case (size)
      3'd6:    code = 3'd4;
      3'd7:    code = 3'd5;
      default: code = size;
    endcase
    case (code)
      3'd0:    mask = 32'h0000_0001;
      3'd1:    mask = 32'h0000_0003;
      3'd2:    mask = 32'h0000_000F;
      3'd3:    mask = 32'h0000_00FF;
      3'd4:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    index   = ({byte_sel, pixa} >> code) << code;
    shifted = phrase >> index;
    return shifted[31:0] & mask;
  endfunction

  assign accept_s  = req_valid && (state_r == IDLE);
  assign hit_s     = CACHE_EN && tag_valid_r && (tag_r == req_address[23:3]) && !inval;
  assign capture_s = ((state_r == REQ) && mem_ack && mem_dvalid) || ((state_r == WAIT) && mem_dvalid);

  // State register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = hit_s ? OUT : REQ;
        else           state_s = IDLE;
      end
      REQ: begin
        if (mem_ack) state_s = mem_dvalid ? OUT : WAIT;
        else         state_s = REQ;
      end
      WAIT: begin
        if (mem_dvalid) state_s = OUT;
        else            state_s = WAIT;
      end
      OUT: begin
        if (pix_ready) state_s = IDLE;
        else           state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Request capture, hold register, tag and extracted pixel
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      byte_r      <= 3'd0;
      pixa_r      <= 3'd0;
      size_r      <= 3'd0;
      mem_addr_r  <= 21'd0;
      hold_r      <= 64'd0;
      tag_r       <= 21'd0;
      tag_valid_r <= 1'b0;
      pix_data_r  <= 32'd0;
    end else begin
      if (accept_s) begin
        byte_r <= req_address[2:0];
        pixa_r <= req_pixa;
        size_r <= req_pixsize;
        if (!hit_s) mem_addr_r <= req_address[23:3];
      end
      if (accept_s && hit_s) begin
        pix_data_r <= extract(hold_r, req_address[2:0], req_pixa, req_pixsize);
      end else if (capture_s) begin
        pix_data_r <= extract(mem_data, byte_r, pixa_r, size_r);
      end
      if (capture_s) begin
        hold_r <= mem_data;
        tag_r  <= mem_addr_r;
      end
      // An invalidate coinciding with a capture wins, so stale data is never marked valid.
      if (inval)          tag_valid_r <= 1'b0;
      else if (capture_s) tag_valid_r <= 1'b1;
    end
  end

  assign req_ready = (state_r == IDLE);
  assign mem_req   = (state_r == REQ);
  assign pix_valid = (state_r == OUT);
  assign mem_addr  = mem_addr_r;
  assign pix_data  = pix_data_r;

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter CACHE_EN, default 1, enables the single-phrase hold register (the hit path); 0 makes every request a miss.
REQ-002 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  pixel read request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_address  in  24  byte address from the address generator; [23:3] is the phrase address, [2:0] is the byte in the phrase.
REQ-007 req_pixa  in  3  bit offset within the byte; meaningful for pixel sizes below 8 bpp.
REQ-008 req_pixsize  in  3  pixel size code: 0=1, 1=2, 2=4, 3=8, 4=16, 5=32 bpp; 6 is treated as 4, 7 as 5.
REQ-009 inval  in  1  invalidates the hold register.
REQ-010 mem_req  out  1  phrase read request to memory.
REQ-011 mem_addr  out  21  phrase address being read.
REQ-012 mem_ack  in  1  memory accepted mem_req.
REQ-013 mem_dvalid  in  1  mem_data is valid this cycle.
REQ-014 mem_data  in  64  phrase read data; bit 0 is the LSB of byte 0.
REQ-015 pix_valid  out  1  extracted pixel is available.
REQ-016 pix_data  out  32  extracted pixel, zero-extended.
REQ-017 pix_ready  in  1  consumer accepts pix_data.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and OUT; req_ready=1 only in IDLE, mem_req=1 only in REQ, pix_valid=1 only in OUT.
REQ-019 On accept (req_valid & req_ready), the block SHALL register address, pixa and pixsize.
REQ-020 Hit (CACHE_EN=1, tag valid, tag == req_address[23:3], inval=0) SHALL go IDLE->OUT: pix_valid is high on the cycle after accept.
REQ-021 Miss SHALL go IDLE->REQ, with mem_addr = req_address[23:3] held stable while in REQ.
REQ-022 REQ: mem_ack=1 -> WAIT; mem_ack=1 together with mem_dvalid=1 -> OUT, capturing the data on that edge.
REQ-023 WAIT: mem_dvalid=1 -> capture mem_data into the hold register, set tag to the phrase address, mark tag valid, go to OUT.
REQ-024 mem_dvalid SHALL be ignored in IDLE, REQ (without mem_ack) and OUT.
REQ-025 Bit index = {addr[2:0], pixa[2:0]}, aligned down to the pixel width (low log2(bpp) bits cleared).
REQ-026 pix_data = hold[index + bpp - 1 : index], zero-extended to 32 bits.
REQ-027 pix_data SHALL be stable while pix_valid=1.
REQ-028 OUT: pix_ready=1 -> IDLE; pix_ready=0 -> remain in OUT.
REQ-029 A request SHALL NOT be accepted in the same cycle the OUT handshake completes (minimum 1 idle cycle between requests).
REQ-030 inval SHALL clear tag valid in any state; if inval is asserted on the accept cycle, the request is a miss.
REQ-031 inval SHALL NOT abort an in-flight miss; that miss's capture sets tag valid again.

Reset
REQ-032 While reset is high, the block SHALL be in IDLE with tag valid=0, hold register, tag and pix_data=0, mem_addr=0, mem_req=0, pix_valid=0 and req_ready=1, immediately and without a clock edge.
REQ-033 Reset during REQ or WAIT SHALL abandon the transfer; a late mem_dvalid after reset is ignored (REQ-024).

Verification
REQ-034 Miss, 8 bpp: addr 0x000103, pixa 0, size 3, mem_data 0x8877665544332211 -> mem_addr 0x000020, pix_data 0x44.
REQ-035 Hit, 16 bpp: then addr 0x000105, size 4 -> no mem_req, pix_valid on the cycle after accept, pix_data 0x6655.
REQ-036 32 bpp alias: addr 0x000104, size 7, same data, inval pulsed on the accept cycle -> mem_req issued, pix_data 0x88776655.
REQ-037 1 bpp, same-cycle ack+data: addr 0x000200, pixa 5, size 0, data 0x20 with mem_ack and mem_dvalid together -> mem_addr 0x000040, no WAIT, pix_data 0x1.
REQ-038 Backpressure and reset: pix_ready held low 5 cycles -> pix_valid and pix_data held; reset asserted in WAIT -> outputs zero, a following mem_dvalid is ignored, the next access to that phrase misses.
